// File: rtl/rs_mul_sched_pkg.sv
// Shared sizes and FSM encoding for the multiply reservation-station scheduler.
package rs_mul_sched_pkg;

    localparam int RS_MUL_ENT_NUM = 2;
    localparam int RS_MUL_ENT_SEL = 1;
    localparam int RRF_ENT_SEL    = 6;
    localparam int MUL_CNT_W      = 4;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_WAIT = 2'd2
    } mul_state_e;

endpackage

// File: rtl/rs_mul_sched_age_matrix_sel.sv
// Age matrix plus oldest-ready pick for a reservation station of ENT_NUM entries.
// older_q[i][j] set means entry i was allocated before entry j.
module age_matrix_sel #(
    parameter int ENT_NUM = 2,
    parameter int ENT_SEL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_en_i,
    input  logic               flush_i,
    input  logic               alloc1_vld_i,
    input  logic [ENT_SEL-1:0] alloc1_sel_i,
    input  logic               alloc2_vld_i,
    input  logic [ENT_SEL-1:0] alloc2_sel_i,
    input  logic               issue_vld_i,
    input  logic [ENT_SEL-1:0] issue_sel_i,
    input  logic [ENT_NUM-1:0] busy_vec_i,
    input  logic [ENT_NUM-1:0] ready_vec_i,
    output logic               ready_any_o,
    output logic [ENT_SEL-1:0] oldest_sel_o
);

    logic [ENT_NUM-1:0] older_q [ENT_NUM];
    logic [ENT_NUM-1:0] older_d [ENT_NUM];
    logic [ENT_NUM-1:0] alloc1_oh;
    logic [ENT_NUM-1:0] alloc2_oh;
    logic [ENT_NUM-1:0] issue_oh;
    logic [ENT_NUM-1:0] cand;

    for (genvar gi = 0; gi < ENT_NUM; gi++) begin : g_ent
        logic [ENT_NUM-1:0] older_col;

        assign alloc1_oh[gi] = alloc1_vld_i && (alloc1_sel_i == ENT_SEL'(gi));
        assign alloc2_oh[gi] = alloc2_vld_i && (alloc2_sel_i == ENT_SEL'(gi));
        assign issue_oh[gi]  = issue_vld_i  && (issue_sel_i  == ENT_SEL'(gi));

        for (genvar gj = 0; gj < ENT_NUM; gj++) begin : g_col
            assign older_col[gj] = older_q[gj][gi];
        end

        // Ready and no other ready entry is older.
        assign cand[gi] = ready_vec_i[gi] && !(|(older_col & ready_vec_i));
    end

    assign ready_any_o = |ready_vec_i;

    always_comb begin
        oldest_sel_o = '0;
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (cand[i]) oldest_sel_o = ENT_SEL'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < ENT_NUM; i++) older_d[i] = older_q[i];
        if (flush_i) begin
            for (int i = 0; i < ENT_NUM; i++) older_d[i] = '0;
        end else if (upd_en_i) begin
            for (int i = 0; i < ENT_NUM; i++) begin
                for (int j = 0; j < ENT_NUM; j++) begin
                    if (alloc1_oh[i] || alloc2_oh[i]) begin
                        // Same-cycle pair: slot 1 is the older one.
                        older_d[i][j] = alloc1_oh[i] && alloc2_oh[j];
                    end else if (alloc1_oh[j] || alloc2_oh[j]) begin
                        older_d[i][j] = busy_vec_i[i];
                    end
                    if (issue_oh[i] || issue_oh[j]) older_d[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENT_NUM; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENT_NUM; i++) older_q[i] <= older_d[i];
        end
    end

endmodule

// File: rtl/rs_mul_sched.sv
// Multiply RS scheduler: entry allocation for two dispatch slots, oldest-ready
// issue, multiplier latency tracking and result-bus handshake.
module rs_mul_sched
    import rs_mul_sched_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_dp_req_1,
    input  logic                      i_dp_req_2,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [RS_MUL_ENT_NUM-1:0] i_busy_vec,
    input  logic [RS_MUL_ENT_NUM-1:0] i_vld_vec,
    output logic                      o_alloc_vld_1,
    output logic                      o_alloc_vld_2,
    output logic [RS_MUL_ENT_SEL-1:0] o_alloc_sel_1,
    output logic [RS_MUL_ENT_SEL-1:0] o_alloc_sel_2,
    output logic                      o_dp_stall_mul,
    output logic                      o_is_vld,
    output logic [RS_MUL_ENT_SEL-1:0] o_is_sel,
    input  logic [RRF_ENT_SEL-1:0]    i_is_rrftag,
    output logic                      o_mul_start,
    output logic                      o_exfin_req,
    input  logic                      i_exfin_gnt,
    output logic                      o_exfin_mul,
    output logic [RRF_ENT_SEL-1:0]    o_ex_mul_rrftag,
    output logic                      o_mul_busy
);

    localparam logic [MUL_CNT_W-1:0] CNT_LOAD = MUL_CNT_W'(MUL_LAT - 1);

    logic                      first_found;
    logic                      second_found;
    logic [RS_MUL_ENT_SEL-1:0] first_sel;
    logic [RS_MUL_ENT_SEL-1:0] second_sel;
    logic                      found_1;
    logic                      found_2;
    logic                      ready_any;

    mul_state_e                state_q, state_d;
    logic [MUL_CNT_W-1:0]      cnt_q, cnt_d;
    logic [RRF_ENT_SEL-1:0]    tag_q, tag_d;

    always_comb begin
        first_found  = 1'b0;
        second_found = 1'b0;
        first_sel    = '0;
        second_sel   = '0;
        for (int i = 0; i < RS_MUL_ENT_NUM; i++) begin
            if (!i_busy_vec[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_sel   = RS_MUL_ENT_SEL'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_sel   = RS_MUL_ENT_SEL'(i);
                end
            end
        end
    end

    // Slot 2 falls back to the lowest free entry when slot 1 is empty.
    assign found_1        = first_found;
    assign found_2        = i_dp_req_1 ? second_found : first_found;
    assign o_alloc_sel_1  = first_sel;
    assign o_alloc_sel_2  = i_dp_req_1 ? second_sel : first_sel;
    assign o_dp_stall_mul = (i_dp_req_1 && !found_1) || (i_dp_req_2 && !found_2);
    assign o_alloc_vld_1  = i_dp_req_1 && found_1 && !o_dp_stall_mul;
    assign o_alloc_vld_2  = i_dp_req_2 && found_2 && !o_dp_stall_mul;

    age_matrix_sel #(
        .ENT_NUM (RS_MUL_ENT_NUM),
        .ENT_SEL (RS_MUL_ENT_SEL)
    ) u_age (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_en_i     (!i_stall),
        .flush_i      (i_flush),
        .alloc1_vld_i (o_alloc_vld_1),
        .alloc1_sel_i (o_alloc_sel_1),
        .alloc2_vld_i (o_alloc_vld_2),
        .alloc2_sel_i (o_alloc_sel_2),
        .issue_vld_i  (o_is_vld),
        .issue_sel_i  (o_is_sel),
        .busy_vec_i   (i_busy_vec),
        .ready_vec_i  (i_busy_vec & i_vld_vec),
        .ready_any_o  (ready_any),
        .oldest_sel_o (o_is_sel)
    );

    assign o_is_vld        = ready_any && (state_q == MUL_IDLE) && !i_flush;
    assign o_mul_start     = o_is_vld;
    assign o_exfin_req     = (state_q == MUL_WAIT);
    assign o_exfin_mul     = o_exfin_req && i_exfin_gnt && !i_flush;
    assign o_mul_busy      = (state_q != MUL_IDLE);
    assign o_ex_mul_rrftag = tag_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        case (state_q)
            MUL_IDLE: begin
                if (o_is_vld) begin
                    // A single-cycle multiply skips BUSY so the request lands at issue+1.
                    state_d = (MUL_LAT == 1) ? MUL_WAIT : MUL_BUSY;
                    cnt_d   = CNT_LOAD;
                    tag_d   = i_is_rrftag;
                end
            end
            MUL_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (i_exfin_gnt) state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
        if (i_flush) begin
            state_d = MUL_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_rs_mul_sched.sv
// Bench for rs_mul_sched: an RS/multiplier model based on allocation order and
// issue timestamps, directed scenarios, then randomized traffic.
module tb_rs_mul_sched;
    import rs_mul_sched_pkg::*;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic dp_req_1, dp_req_2, ext_stall, flush, gnt;
    logic stall;
    logic [1:0] busy_vec, vld_vec;
    logic [RRF_ENT_SEL-1:0] is_rrftag;
    logic alloc_vld_1, alloc_vld_2, dp_stall_mul, is_vld, mul_start;
    logic exfin_req, exfin_mul, mul_busy;
    logic [RS_MUL_ENT_SEL-1:0] alloc_sel_1, alloc_sel_2, is_sel;
    logic [RRF_ENT_SEL-1:0] ex_tag;

    // Bench-side RS contents and multiplier bookkeeping.
    logic [1:0] m_busy, m_rdy;
    logic [RRF_ENT_SEL-1:0] m_tag [2];
    int m_stamp [2];
    int stamp_ctr;
    bit mul_act;
    int iss_cyc;
    int cyc;
    logic [RRF_ENT_SEL-1:0] last_tag;

    int vectors;
    int miscompares;

    logic s_v1, s_v2, s_stall, s_isv, s_req, s_mul, s_mbusy;
    logic [RS_MUL_ENT_SEL-1:0] s_s1, s_s2, s_issel;
    logic [RRF_ENT_SEL-1:0] s_tag;

    assign stall     = ext_stall | dp_stall_mul;
    assign busy_vec  = m_busy;
    assign vld_vec   = m_busy & m_rdy;
    assign is_rrftag = m_tag[is_sel];

    rs_mul_sched #(.MUL_LAT(L)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_dp_req_1      (dp_req_1),
        .i_dp_req_2      (dp_req_2),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_busy_vec      (busy_vec),
        .i_vld_vec       (vld_vec),
        .o_alloc_vld_1   (alloc_vld_1),
        .o_alloc_vld_2   (alloc_vld_2),
        .o_alloc_sel_1   (alloc_sel_1),
        .o_alloc_sel_2   (alloc_sel_2),
        .o_dp_stall_mul  (dp_stall_mul),
        .o_is_vld        (is_vld),
        .o_is_sel        (is_sel),
        .i_is_rrftag     (is_rrftag),
        .o_mul_start     (mul_start),
        .o_exfin_req     (exfin_req),
        .i_exfin_gnt     (gnt),
        .o_exfin_mul     (exfin_mul),
        .o_ex_mul_rrftag (ex_tag),
        .o_mul_busy      (mul_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic model_clear();
        m_busy   = '0;
        m_rdy    = '0;
        mul_act  = 1'b0;
        last_tag = '0;
        for (int i = 0; i < 2; i++) begin
            m_tag[i]   = '0;
            m_stamp[i] = 0;
        end
    endtask

    task automatic model_alloc(input int e);
        m_busy[e]  = 1'b1;
        m_rdy[e]   = 1'b0;
        m_tag[e]   = RRF_ENT_SEL'($urandom);
        m_stamp[e] = stamp_ctr;
        stamp_ctr++;
    endtask

    // One clock: check outputs at negedge against the model, then advance the model past posedge.
    task automatic step();
        int fl [2];
        int nfree, best, e_s1, e_s2;
        logic e_stall, e_v1, e_v2, e_isv, e_req, e_mul;
        @(negedge clk);
        nfree = 0;
        fl[0] = 0;
        fl[1] = 0;
        for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                fl[nfree] = i;
                nfree++;
            end
        end
        e_stall = (int'(dp_req_1) + int'(dp_req_2)) > nfree;
        e_v1    = dp_req_1 && !e_stall;
        e_v2    = dp_req_2 && !e_stall;
        e_s1    = fl[0];
        e_s2    = dp_req_1 ? fl[1] : fl[0];
        best = -1;
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] && m_rdy[i] && (best < 0 || m_stamp[i] < m_stamp[best])) best = i;
        end
        e_isv = (best >= 0) && !mul_act && !flush;
        e_req = mul_act && ((cyc - iss_cyc) >= L);
        e_mul = e_req && gnt && !flush;

        s_v1 = alloc_vld_1; s_v2 = alloc_vld_2; s_s1 = alloc_sel_1; s_s2 = alloc_sel_2;
        s_stall = dp_stall_mul; s_isv = is_vld; s_issel = is_sel; s_req = exfin_req;
        s_mul = exfin_mul; s_mbusy = mul_busy; s_tag = ex_tag;

        chk("alloc_vld_1", 32'(s_v1), 32'(e_v1));
        chk("alloc_vld_2", 32'(s_v2), 32'(e_v2));
        if (e_v1) chk("alloc_sel_1", 32'(s_s1), 32'(e_s1));
        if (e_v2) chk("alloc_sel_2", 32'(s_s2), 32'(e_s2));
        chk("dp_stall_mul", 32'(s_stall), 32'(e_stall));
        chk("is_vld", 32'(s_isv), 32'(e_isv));
        if (e_isv) chk("is_sel", 32'(s_issel), 32'(best));
        chk("mul_start", 32'(mul_start), 32'(e_isv));
        chk("exfin_req", 32'(s_req), 32'(e_req));
        chk("exfin_mul", 32'(s_mul), 32'(e_mul));
        chk("mul_busy", 32'(s_mbusy), 32'(mul_act));
        chk("ex_mul_rrftag", 32'(s_tag), 32'(last_tag));
        if (e_mul) $display("cycle %0d: multiply done, tag 0x%0h", cyc, last_tag);

        @(posedge clk);
        #1;
        if (flush) begin
            mul_act = 1'b0;
            m_busy  = '0;
            m_rdy   = '0;
        end else begin
            if (e_mul) mul_act = 1'b0;
            if (e_isv) begin
                mul_act      = 1'b1;
                iss_cyc      = cyc;
                last_tag     = m_tag[best];
                m_busy[best] = 1'b0;
                m_rdy[best]  = 1'b0;
            end
            if (!ext_stall) begin
                if (e_v1) model_alloc(e_s1);
                if (e_v2) model_alloc(e_s2);
            end
        end
        cyc++;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        gnt  = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            if (m_busy == 2'b00 && !mul_act) done = 1'b1;
            else begin
                m_rdy = m_busy;
                step();
            end
        end
        if (!done) timeout_fail("drain");
        gnt = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            if (s_isv) done = 1'b1;
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic wait_req(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            if (s_req) done = 1'b1;
        end
        if (!done) timeout_fail(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vectors = 0; miscompares = 0; cyc = 0; stamp_ctr = 0; iss_cyc = 0;
        model_clear();
        rst_n = 1'b0; dp_req_1 = 1'b1; dp_req_2 = 1'b1; ext_stall = 1'b0; flush = 1'b0; gnt = 1'b0;
        #2;
        chk("rst_is_vld", 32'(is_vld), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_exfin_req", 32'(exfin_req), 32'd0);
        chk("rst_exfin_mul", 32'(exfin_mul), 32'd0);
        chk("rst_mul_busy", 32'(mul_busy), 32'd0);
        chk("rst_tag", 32'(ex_tag), 32'd0);
        chk("rst_alloc_vld_2", 32'(alloc_vld_2), 32'd1);
        chk("rst_alloc_sel_2", 32'(alloc_sel_2), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; dp_req_1 = 1'b0; dp_req_2 = 1'b0;

        // Idle allocation, then entry 0 issues first.
        dp_req_1 = 1'b1; dp_req_2 = 1'b1; step();
        chk("idle_sel_1", 32'(s_s1), 32'd0);
        chk("idle_sel_2", 32'(s_s2), 32'd1);
        chk("idle_stall", 32'(s_stall), 32'd0);
        dp_req_1 = 1'b0; dp_req_2 = 1'b0; m_rdy = 2'b11; step();
        chk("idle_issue_vld", 32'(s_isv), 32'd1);
        chk("idle_issue_sel", 32'(s_issel), 32'd0);
        drain();

        // Partial free.
        dp_req_1 = 1'b1; step();
        dp_req_2 = 1'b1; step();
        chk("part_stall", 32'(s_stall), 32'd1);
        chk("part_vld_1", 32'(s_v1), 32'd0);
        chk("part_vld_2", 32'(s_v2), 32'd0);
        dp_req_1 = 1'b0; step();
        chk("part_slot2_vld", 32'(s_v2), 32'd1);
        chk("part_slot2_sel", 32'(s_s2), 32'd1);
        dp_req_2 = 1'b0;
        drain();

        // Age order: entry 0 is re-allocated after entry 1, so entry 1 goes first.
        dp_req_1 = 1'b1; dp_req_2 = 1'b1; step();
        dp_req_1 = 1'b0; dp_req_2 = 1'b0; m_rdy[0] = 1'b1; step();
        step();
        dp_req_1 = 1'b1; step();
        dp_req_1 = 1'b0; m_rdy = 2'b11; gnt = 1'b1;
        wait_issue("age_first_wait");
        chk("age_first_sel", 32'(s_issel), 32'd1);
        wait_issue("age_second_wait");
        chk("age_second_sel", 32'(s_issel), 32'd0);
        drain();

        // Latency and handshake with tag 0x1A.
        dp_req_1 = 1'b1; step(); dp_req_1 = 1'b0;
        m_tag[0] = 6'h1A; m_rdy[0] = 1'b1; gnt = 1'b0; step();
        chk("lat_issue", 32'(s_isv), 32'd1);
        n = 0;
        dp_req_1 = 1'b1;
        for (int k = 1; k <= 10 && n == 0; k++) begin
            step();
            dp_req_1 = 1'b0;
            m_rdy = m_busy;
            if (s_req) n = k;
        end
        chk("lat_req_offset", 32'(n), 32'd4);
        step();
        chk("lat_hold_req", 32'(s_req), 32'd1);
        chk("lat_no_fin", 32'(s_mul), 32'd0);
        gnt = 1'b1; step();
        chk("lat_fin", 32'(s_mul), 32'd1);
        chk("lat_fin_tag", 32'(s_tag), 32'h1A);
        gnt = 1'b0; step();
        chk("lat_next_issue", 32'(s_isv), 32'd1);
        drain();

        // Flush while BUSY.
        dp_req_1 = 1'b1; dp_req_2 = 1'b1; step();
        dp_req_1 = 1'b0; dp_req_2 = 1'b0; m_rdy[0] = 1'b1; step();
        m_rdy[1] = 1'b1; step();
        gnt = 1'b1; flush = 1'b1; step();
        chk("flush_no_issue", 32'(s_isv), 32'd0);
        chk("flush_no_fin", 32'(s_mul), 32'd0);
        flush = 1'b0; gnt = 1'b0; step();
        chk("flush_idle", 32'(s_mbusy), 32'd0);

        // Grant and flush in the same cycle.
        dp_req_1 = 1'b1; step(); dp_req_1 = 1'b0; m_rdy[0] = 1'b1; step();
        wait_req("flushgnt_wait");
        gnt = 1'b1; flush = 1'b1; step();
        chk("flushgnt_no_fin", 32'(s_mul), 32'd0);
        gnt = 1'b0; flush = 1'b0; step();
        chk("flushgnt_idle", 32'(s_mbusy), 32'd0);

        // Asynchronous reset while WAITing for the bus.
        dp_req_1 = 1'b1; step(); dp_req_1 = 1'b0;
        m_tag[0] = 6'h2B; m_rdy[0] = 1'b1; step();
        wait_req("arst_wait");
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_exfin_req", 32'(exfin_req), 32'd0);
        chk("arst_mul_busy", 32'(mul_busy), 32'd0);
        chk("arst_is_vld", 32'(is_vld), 32'd0);
        chk("arst_mul_start", 32'(mul_start), 32'd0);
        chk("arst_exfin_mul", 32'(exfin_mul), 32'd0);
        chk("arst_tag", 32'(ex_tag), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic.
        repeat (1500) begin
            dp_req_1  = 1'($urandom_range(0, 1));
            dp_req_2  = 1'($urandom_range(0, 1));
            ext_stall = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            gnt       = 1'($urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i] && !m_rdy[i] && $urandom_range(0, 2) == 0) m_rdy[i] = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rs_mul_sched.md
# rs_mul_sched

Scheduler and sequencer for the two-entry multiply reservation station. It picks free entries for up to two dispatched MUL instructions per cycle and tracks entry age. It issues the oldest ready entry to an iterative multiplier, counts the multiply latency, and requests the result bus, handing the finished `rrftag` to the wakeup network. It sits between dispatch, `rs_mul`, the multiplier and the CDB arbiter.

## Interface
- `MUL_LAT`, default 4: multiplier cycles from `o_mul_start` to result valid; legal range 1..15.
- Entry count and select width come from `RS_MUL_ENT_NUM` (2) and `RS_MUL_ENT_SEL` (1) in `constants.vh`.
- Tag width comes from `RRF_ENT_SEL`.

Ports:
- `clk`  in  1  Single clock for the block.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `i_dp_req_1`, `i_dp_req_2`  in  1  Dispatch slot 1/2 holds a MUL instruction.
- `i_stall`  in  1  Global dispatch stall, which already includes `o_dp_stall_mul`.
- `i_flush`  in  1  Mispredict flush: aborts the in-flight multiply and clears age state.
- `i_busy_vec`, `i_vld_vec`  in  `RS_MUL_ENT_NUM`  Entry occupied / entry operands ready, from the RS.
- `o_alloc_vld_1`, `o_alloc_vld_2`  out  1  Allocation valid per slot.
- `o_alloc_sel_1`, `o_alloc_sel_2`  out  `RS_MUL_ENT_SEL`  Entry chosen per slot.
- `o_dp_stall_mul`  out  1  Not enough free entries for the MUL requests this cycle.
- `o_is_vld`, `o_is_sel`  out  1 / `RS_MUL_ENT_SEL`  Issue read strobe and entry select to the RS.
- `i_is_rrftag`  in  `RRF_ENT_SEL`  Tag read from the RS for the selected entry.
- `o_mul_start`  out  1  One-cycle start pulse to the multiplier.
- `o_exfin_req`  out  1  Result-bus request.
- `i_exfin_gnt`  in  1  Result-bus grant.
- `o_exfin_mul`  out  1  Finish strobe, equal to `o_exfin_req & i_exfin_gnt`.
- `o_ex_mul_rrftag`  out  `RRF_ENT_SEL`  Tag of the in-flight or finishing multiply.
- `o_mul_busy`  out  1  FSM is not IDLE.

## Operation
- **Allocation (combinational from `i_busy_vec`)**
  - Slot 1 takes the lowest free entry.
  - Slot 2 takes the next free entry; if slot 1 did not request, slot 2 takes the lowest free entry.
  - `o_alloc_vld_x = i_dp_req_x & entry_found`.
  - `o_dp_stall_mul = 1` when the number of requests exceeds the number of free entries. When it is 1, both alloc valids are 0, so dispatch is all-or-nothing.
- **Age matrix** `older[i][j]` means entry i is older than entry j.
  - Updated only when `!i_stall`.
  - A newly allocated entry becomes younger than every busy entry.
  - When both slots allocate, slot 1 is older than slot 2.
  - The row and column of the issued entry are cleared on issue.
  - `i_flush` clears the whole matrix.
- **Issue select:** the oldest entry with `i_busy_vec & i_vld_vec` set, i.e. an entry with no older ready entry. If no age relation exists, the lowest index wins.
  - `o_is_vld = ready_any & state==IDLE & !i_flush`.
- **FSM**
  - IDLE → BUSY on `o_is_vld`. In that cycle: `o_mul_start = 1`, `i_is_rrftag` is captured into `o_ex_mul_rrftag`, and `cnt` is loaded with `MUL_LAT-1`.
  - BUSY: `cnt` decrements each cycle. At `cnt==0` the FSM moves to WAIT.
  - WAIT: `o_exfin_req = 1`. It holds the request until `i_exfin_gnt`, then goes to IDLE.
  - `i_flush` in any state forces IDLE next cycle and blocks `o_exfin_mul` in that cycle.
- `o_ex_mul_rrftag` holds its value from issue until the next issue.
- `cnt` is 4 bits wide.

## Timing
- **Reset values:**
  - `state` is IDLE; `cnt` is 0; the age matrix is all 0; `o_ex_mul_rrftag` is 0.
  - All strobes are 0: `o_is_vld`, `o_mul_start`, `o_exfin_req`, `o_exfin_mul`, `o_mul_busy`.
  - Alloc outputs follow `i_busy_vec`.
- **Issue-to-request latency:** issue at cycle t puts `o_exfin_req` high at t+`MUL_LAT`.
- **Next issue:** with a grant at cycle g, the next issue is possible at g+1.
- **Freed entry:** an entry issued at t sees `i_busy_vec` drop at t+1 and can be re-allocated at t+1.
- **Allocation and issue in the same cycle** on different entries are independent.
- **Grant and flush in the same cycle:** flush wins and `o_exfin_mul = 0`.
- **Reset mid-operation** drops any in-flight multiply silently.

## Structure
- FSM state encodings (IDLE/BUSY/WAIT) and `MUL_CNT_W = 4` go into `constants.vh` alongside the `RS_MUL_*` widths.
- One sub-module: `age_matrix_sel`, parameterised on entry count. It holds the age-matrix registers and the oldest-ready selection and is reusable for the other reservation stations.
- Allocation logic and the FSM live in the top module.

## Test plan
- **Idle allocation:** `busy = 00`, both requests → `sel_1 = 0`, `sel_2 = 1`, stall 0. Then with `vld = 11`, entry 0 issues first.
- **Partial free:** `busy = 01`, both requests → `o_dp_stall_mul = 1`, both alloc valids 0. A single request on slot 2 → `sel_2 = 1`.
- **Age order:** allocate entry 1, then entry 0 two cycles later; make both ready → entry 1 issues, and entry 0 issues after that multiply is granted.
- **Latency with `MUL_LAT = 4`, tag 0x1A:** issue at t=10 → `o_exfin_req` rises at t=14. Grant at t=16 → `o_exfin_mul` is high only at t=16 with tag 0x1A, and the next issue occurs at t=17.
- **Flush:** assert `i_flush` in BUSY → IDLE next cycle, no `o_exfin_mul`, age matrix cleared, and no issue in the flush cycle.
- **Async reset mid-WAIT:** all outputs return to reset values immediately, with no clock edge required.
